wb_port_arbiter: RTL and testbench



---
 rtl/wb_port_arbiter_pkg.sv | 15 +
 rtl/wb_skid_buf.sv | 43 ++++
 rtl/wb_port_arbiter.sv | 136 +++++++++++++
 tb/tb_wb_port_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter.
// Default widths, the x0 register index and the arbiter FSM state encoding.
package wb_port_arbiter_pkg;

   localparam int unsigned DefDataW = 32;
   localparam int unsigned DefAddrW = 5;
   localparam int unsigned RegX0    = 0;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StHold  = 2'd1,
      StForce = 2'd2
   } arb_state_e;

endpackage

// File: rtl/wb_skid_buf.sv
// One-entry parking register for a long-latency result that lost the write port.
// Drain and drop both empty the entry; capture only happens while it is empty.
module wb_skid_buf
   import wb_port_arbiter_pkg::*;
#(
   parameter int unsigned DATA_W = DefDataW,
   parameter int unsigned ADDR_W = DefAddrW
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              capture,
   input  logic              drain,
   input  logic              drop,
   input  logic [ADDR_W-1:0] cap_rd,
   input  logic [DATA_W-1:0] cap_data,
   output logic              valid,
   output logic [ADDR_W-1:0] rd,
   output logic [DATA_W-1:0] data
);

   logic              valid_q;
   logic [ADDR_W-1:0] rd_q;
   logic [DATA_W-1:0] data_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         rd_q    <= '0;
         data_q  <= '0;
      end else if (drain || drop) begin
         valid_q <= 1'b0;
      end else if (capture) begin
         valid_q <= 1'b1;
         rd_q    <= cap_rd;
         data_q  <= cap_data;
      end
   end

   assign valid = valid_q;
   assign rd    = rd_q;
   assign data  = data_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between pipeline writeback and a long-latency unit.
// Pipeline always wins; a blocked lu result is parked and a stall is forced if it starves.
module wb_port_arbiter
   import wb_port_arbiter_pkg::*;
#(
   parameter int unsigned DATA_W   = DefDataW,
   parameter int unsigned ADDR_W   = DefAddrW,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              reg_write_w,
   input  logic [ADDR_W-1:0] rd_w,
   input  logic [DATA_W-1:0] result_w,
   input  logic              lu_valid,
   input  logic [ADDR_W-1:0] lu_rd,
   input  logic [DATA_W-1:0] lu_data,
   output logic              lu_ready,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_wa,
   output logic [DATA_W-1:0] rf_wd,
   output logic              stall_o,
   output logic              buf_valid_o,
   output logic [ADDR_W-1:0] buf_rd_o,
   output logic              waw_drop
);

   localparam int unsigned CntW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

   arb_state_e        state_q, state_d;
   logic [CntW-1:0]   wait_q, wait_d;
   logic              waw_drop_q;
   logic              buf_valid;
   logic [ADDR_W-1:0] buf_rd;
   logic [DATA_W-1:0] buf_data;
   logic              slot_busy, lu_live, waw_buf, waw_lu;
   logic              capture, drain, drop, we_int;

   assign slot_busy = reg_write_w && (rd_w != ADDR_W'(RegX0));
   assign lu_ready  = !buf_valid;
   assign lu_live   = lu_valid && lu_ready && (lu_rd != ADDR_W'(RegX0));
   // A younger pipeline write to the same register makes the lu result dead.
   assign waw_buf   = slot_busy && buf_valid && (rd_w == buf_rd);
   assign waw_lu    = slot_busy && lu_live && (rd_w == lu_rd);
   assign capture   = slot_busy && lu_live && !waw_lu;
   assign drain     = !slot_busy && buf_valid;
   assign drop      = waw_buf;

   wb_skid_buf #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_skid (
      .clk      (clk),
      .reset    (reset),
      .capture  (capture),
      .drain    (drain),
      .drop     (drop),
      .cap_rd   (lu_rd),
      .cap_data (lu_data),
      .valid    (buf_valid),
      .rd       (buf_rd),
      .data     (buf_data)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         wait_q     <= '0;
         waw_drop_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_q     <= wait_d;
         waw_drop_q <= waw_buf || waw_lu;
      end
   end

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      unique case (state_q)
         StIdle: begin
            if (capture) begin
               state_d = StHold;
               wait_d  = '0;
            end
         end
         StHold: begin
            // With the buffer full, a free slot always drains, so else means blocked.
            if (drain || drop) begin
               state_d = StIdle;
               wait_d  = '0;
            end else if (wait_q == CntW'(MAX_WAIT - 1)) begin
               state_d = StForce;
            end else begin
               wait_d = wait_q + CntW'(1);
            end
         end
         StForce: begin
            if (drain || drop) begin
               state_d = StIdle;
               wait_d  = '0;
            end
         end
         default: begin
            state_d = StIdle;
            wait_d  = '0;
         end
      endcase
   end

   always_comb begin
      stall_o = (state_q == StForce);
      we_int  = 1'b0;
      rf_wa   = '0;
      rf_wd   = '0;
      if (slot_busy) begin
         we_int = 1'b1;
         rf_wa  = rd_w;
         rf_wd  = result_w;
      end else if (buf_valid) begin
         we_int = 1'b1;
         rf_wa  = buf_rd;
         rf_wd  = buf_data;
      end else if (lu_live) begin
         we_int = 1'b1;
         rf_wa  = lu_rd;
         rf_wd  = lu_data;
      end
      rf_we = we_int && !reset;
   end

   assign buf_valid_o = buf_valid;
   assign buf_rd_o    = buf_rd;
   assign waw_drop    = waw_drop_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: the driver predicts each cycle's outputs from a
// pending-result model and queues them; a negedge monitor pops and compares.
module tb_wb_port_arbiter;

   localparam int MAX_WAIT = 4;

   logic        clk, reset;
   logic        reg_write_w, lu_valid;
   logic [4:0]  rd_w, lu_rd;
   logic [31:0] result_w, lu_data;
   logic        lu_ready, rf_we, stall_o, buf_valid_o, waw_drop;
   logic [4:0]  rf_wa, buf_rd_o;
   logic [31:0] rf_wd;

   wb_port_arbiter #(
      .DATA_W   (32),
      .ADDR_W   (5),
      .MAX_WAIT (MAX_WAIT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .reg_write_w (reg_write_w),
      .rd_w        (rd_w),
      .result_w    (result_w),
      .lu_valid    (lu_valid),
      .lu_rd       (lu_rd),
      .lu_data     (lu_data),
      .lu_ready    (lu_ready),
      .rf_we       (rf_we),
      .rf_wa       (rf_wa),
      .rf_wd       (rf_wd),
      .stall_o     (stall_o),
      .buf_valid_o (buf_valid_o),
      .buf_rd_o    (buf_rd_o),
      .waw_drop    (waw_drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        stall;
      logic        bv;
      logic [4:0]  brd;
      logic        ready;
      logic        waw;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model: at most one pending lu result plus how many busy slots it has waited.
   bit          m_pend;
   logic [4:0]  m_rd;
   logic [31:0] m_data;
   int          m_blocked;
   bit          m_waw;

   function automatic void chk(input string name, input logic [31:0] act,
                               input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("rf_we", 32'(rf_we), 32'(e.we));
         if (e.we) begin
            chk("rf_wa", 32'(rf_wa), 32'(e.wa));
            chk("rf_wd", rf_wd, e.wd);
         end
         chk("stall_o", 32'(stall_o), 32'(e.stall));
         chk("buf_valid_o", 32'(buf_valid_o), 32'(e.bv));
         if (e.bv) chk("buf_rd_o", 32'(buf_rd_o), 32'(e.brd));
         chk("lu_ready", 32'(lu_ready), 32'(e.ready));
         chk("waw_drop", 32'(waw_drop), 32'(e.waw));
      end
   end

   task automatic step(input bit rst, input bit rw, input logic [4:0] rd,
                       input logic [31:0] res, input bit lv, input logic [4:0] lrd,
                       input logic [31:0] ld);
      exp_t e;
      bit   busy, live;
      @(posedge clk);
      #1;
      reset       = rst;
      reg_write_w = rw;
      rd_w        = rd;
      result_w    = res;
      lu_valid    = lv;
      lu_rd       = lrd;
      lu_data     = ld;
      e.wa = '0;
      e.wd = '0;
      e.brd = '0;
      if (rst) begin
         e.we = 0; e.stall = 0; e.bv = 0; e.ready = 1; e.waw = 0;
         m_pend = 0; m_rd = '0; m_data = '0; m_blocked = 0; m_waw = 0;
      end else begin
         busy = rw && (rd != 0);
         live = lv && !m_pend && (lrd != 0);
         e.stall = m_pend && (m_blocked >= MAX_WAIT);
         e.bv    = m_pend;
         e.brd   = m_rd;
         e.ready = !m_pend;
         e.waw   = m_waw;
         if (busy) begin
            e.we = 1; e.wa = rd; e.wd = res;
         end else if (m_pend) begin
            e.we = 1; e.wa = m_rd; e.wd = m_data;
         end else if (live) begin
            e.we = 1; e.wa = lrd; e.wd = ld;
         end else begin
            e.we = 0;
         end
         m_waw = busy && ((m_pend && rd == m_rd) || (live && rd == lrd));
         if (m_pend) begin
            if (!busy || rd == m_rd) begin
               m_pend    = 0;
               m_blocked = 0;
            end else begin
               m_blocked++;
            end
         end else if (live && busy && rd != lrd) begin
            m_pend    = 1;
            m_rd      = lrd;
            m_data    = ld;
            m_blocked = 0;
         end
      end
      exp_q.push_back(e);
   endtask

   task automatic idle();
      step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
   endtask

   initial begin
      int busy_pct;
      reset = 1'b1; reg_write_w = 0; rd_w = 0; result_w = 0;
      lu_valid = 0; lu_rd = 0; lu_data = 0;
      m_pend = 0; m_rd = '0; m_data = '0; m_blocked = 0; m_waw = 0;
      step(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      step(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      idle();
      // Bypass on a free slot.
      step(0, 0, 5'd0, 32'd0, 1, 5'd5, 32'hDEADBEEF);
      idle();
      // Buffer then drain.
      step(0, 1, 5'd3, 32'hAAAA, 1, 5'd7, 32'h11);
      idle();
      idle();
      // Starvation into forced stall, then release.
      step(0, 1, 5'd3, 32'h1, 1, 5'd7, 32'h55);
      for (int i = 0; i < 6; i++) step(0, 1, 5'd4, 32'(i), 0, 5'd0, 32'd0);
      idle();
      idle();
      // WAW: younger pipeline write to the buffered destination.
      step(0, 1, 5'd3, 32'h2, 1, 5'd9, 32'h99);
      step(0, 1, 5'd9, 32'h22, 0, 5'd0, 32'd0);
      idle();
      idle();
      // WAW on the incoming lu result itself.
      step(0, 1, 5'd12, 32'h33, 1, 5'd12, 32'h44);
      idle();
      // x0 handling.
      step(0, 0, 5'd0, 32'd0, 1, 5'd0, 32'h99);
      step(0, 1, 5'd2, 32'h5, 1, 5'd6, 32'h66);
      step(0, 1, 5'd0, 32'h77, 0, 5'd0, 32'd0);
      idle();
      // Reset mid-HOLD.
      step(0, 1, 5'd2, 32'h5, 1, 5'd6, 32'h66);
      step(0, 1, 5'd3, 32'h6, 0, 5'd0, 32'd0);
      step(1, 1, 5'd3, 32'h6, 1, 5'd8, 32'h88);
      idle();
      idle();
      // Randomized phases alternating moderate and heavy pipeline pressure.
      for (int i = 0; i < 3000; i++) begin
         busy_pct = ((i / 200) % 2 == 0) ? 55 : 95;
         step(($urandom_range(0, 499) == 0),
              ($urandom_range(0, 99) < busy_pct),
              5'($urandom_range(0, 7)), $urandom,
              ($urandom_range(0, 99) < 45),
              5'($urandom_range(0, 7)), $urandom);
      end
      idle();
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain_queue: got %0d pending, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
